// File: rtl/seq_detector_param_if.sv
// Board-side signal group for the serial pattern detector: data/mode switches in, LED bank out.
interface seq_detector_param_if;
  logic       data;   // SW[2]
  logic       mode;   // SW[3]: 0 = overlapping, 1 = non-overlapping
  logic [9:0] ledr;   // LEDR[9:0]

  modport master (output data, output mode, input  ledr);
  modport slave  (input  data, input  mode, output ledr);
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with match pulse and saturating hit counter.
// Board mapping: i_clk = SW[0], i_rst = SW[1]; data/mode/LEDR travel through io_bus.
module seq_detector_param #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter int                   CNT_W     = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  seq_detector_param_if.slave  io_bus
);

  if (PATTERN_W < 2 || PATTERN_W > 16) begin : g_bad_pattern_w
    $fatal(1, "seq_detector_param: PATTERN_W must be 2..16");
  end
  if (CNT_W < 1 || CNT_W > 8) begin : g_bad_cnt_w
    $fatal(1, "seq_detector_param: CNT_W must be 1..8");
  end

  localparam int                 FILL_W  = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0]  FULL    = FILL_W'(PATTERN_W);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  logic [PATTERN_W-1:0] r_hist;
  logic [FILL_W-1:0]    r_fill;
  logic                 r_match;
  logic [CNT_W-1:0]     r_count;

  logic [PATTERN_W-1:0] w_hist_next;
  logic [FILL_W-1:0]    w_fill_adv;
  logic [FILL_W-1:0]    w_fill_next;
  logic                 w_hit;
  logic [CNT_W-1:0]     w_count_next;
  logic [7:0]           w_cnt_led;

  // The fill guard keeps reset-time zeros in r_hist from ever producing a hit.
  always_comb begin
    w_hist_next  = {r_hist[PATTERN_W-2:0], io_bus.data};
    w_fill_adv   = (r_fill == FULL) ? FULL : r_fill + 1'b1;
    w_hit        = (w_fill_adv == FULL) && (w_hist_next == PATTERN);
    w_fill_next  = (w_hit && io_bus.mode) ? '0 : w_fill_adv;
    w_count_next = (w_hit && (r_count != CNT_MAX)) ? r_count + 1'b1 : r_count;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
      r_count <= '0;
    end else begin
      r_hist  <= w_hist_next;
      r_fill  <= w_fill_next;
      r_match <= w_hit;
      r_count <= w_count_next;
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_cnt_led
    if (gi < CNT_W) begin : g_used
      assign w_cnt_led[gi] = r_count[gi];
    end else begin : g_tied
      assign w_cnt_led[gi] = 1'b0;
    end
  end

  assign io_bus.ledr = {(r_count == CNT_MAX), w_cnt_led, r_match};

endmodule
